// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory path: access sizes, store FSM states,
// and the byte-enable width of the memory write port.
package mips_mem_pkg;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } store_state_e;

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement for a store: narrows the register value to its size
// and shifts data and enables across a two-word window so split accesses fall out naturally.
module store_lane_shifter
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  output logic [7:0]  o_mask8,
  output logic [63:0] o_data64,
  output logic        o_split,
  output logic        o_illegal
);

  logic [7:0]  w_base_mask;
  logic [31:0] w_size_mask;

  always_comb begin
    w_base_mask = 8'h00;
    w_size_mask = 32'h0000_0000;
    o_illegal   = 1'b0;
    case (i_size)
      SZ_BYTE: begin w_base_mask = 8'h01; w_size_mask = 32'h0000_00FF; end
      SZ_HALF: begin w_base_mask = 8'h03; w_size_mask = 32'h0000_FFFF; end
      SZ_WORD: begin w_base_mask = 8'h0F; w_size_mask = 32'hFFFF_FFFF; end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_mask8  = w_base_mask << i_off;
  assign o_data64 = {32'h0, i_data & w_size_mask} << {i_off, 3'b000};
  // Any enable landing in the upper word means the access crosses a word boundary.
  assign o_split  = |o_mask8[7:4];

endmodule

// File: rtl/store_data_aligner.sv
// Store-path formatter: turns a register store into one or two word-aligned write beats
// with byte enables, with a single outstanding request at a time.
module store_data_aligner
  import mips_mem_pkg::*;
#(
  parameter int unsigned ALLOW_SPLIT = 1
)
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_data,
  input  logic [1:0]        i_size,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [BE_W-1:0]   o_mem_be,
  output logic              o_done,
  output logic              o_err
);

  store_state_e    r_state, w_state_next;
  logic            r_mem_valid, w_mem_valid_next;
  logic [31:0]     r_mem_addr, w_mem_addr_next;
  logic [31:0]     r_mem_wdata, w_mem_wdata_next;
  logic [BE_W-1:0] r_mem_be, w_mem_be_next;
  logic            r_done, w_done_next;
  logic            r_err, w_err_next;
  logic            r_split, w_split_next;
  logic [31:0]     r_b1_addr, w_b1_addr_next;
  logic [31:0]     r_b1_wdata, w_b1_wdata_next;
  logic [BE_W-1:0] r_b1_be, w_b1_be_next;

  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic        w_split;
  logic        w_illegal;
  logic [31:0] w_base_addr;

  store_lane_shifter u_shifter (
    .i_off     (i_addr[1:0]),
    .i_data    (i_data),
    .i_size    (i_size),
    .o_mask8   (w_mask8),
    .o_data64  (w_data64),
    .o_split   (w_split),
    .o_illegal (w_illegal)
  );

  assign w_base_addr = {i_addr[31:2], 2'b00};
  assign o_ready     = (r_state == ST_IDLE) & ~i_rst;

  always_comb begin
    w_state_next     = r_state;
    w_mem_valid_next = r_mem_valid;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_be_next    = r_mem_be;
    w_split_next     = r_split;
    w_b1_addr_next   = r_b1_addr;
    w_b1_wdata_next  = r_b1_wdata;
    w_b1_be_next     = r_b1_be;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid && o_ready) begin
          if (w_illegal || (w_split && (ALLOW_SPLIT == 0))) begin
            w_err_next = 1'b1;
          end else begin
            w_state_next     = ST_BEAT0;
            w_mem_valid_next = 1'b1;
            w_mem_addr_next  = w_base_addr;
            w_mem_be_next    = w_mask8[3:0];
            w_mem_wdata_next = w_data64[31:0];
            w_split_next     = w_split;
            // Address arithmetic wraps at 2^32 so the top word's successor is word 0.
            w_b1_addr_next   = w_base_addr + 32'd4;
            w_b1_be_next     = w_mask8[7:4];
            w_b1_wdata_next  = w_data64[63:32];
          end
        end
      end
      ST_BEAT0: begin
        if (i_mem_ready) begin
          if (r_split) begin
            w_state_next     = ST_BEAT1;
            w_mem_addr_next  = r_b1_addr;
            w_mem_be_next    = r_b1_be;
            w_mem_wdata_next = r_b1_wdata;
          end else begin
            w_state_next     = ST_IDLE;
            w_mem_valid_next = 1'b0;
            w_mem_addr_next  = 32'h0;
            w_mem_be_next    = '0;
            w_mem_wdata_next = 32'h0;
            w_done_next      = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (i_mem_ready) begin
          w_state_next     = ST_IDLE;
          w_mem_valid_next = 1'b0;
          w_mem_addr_next  = 32'h0;
          w_mem_be_next    = '0;
          w_mem_wdata_next = 32'h0;
          w_done_next      = 1'b1;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_mem_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_split     <= 1'b0;
      r_b1_addr   <= 32'h0;
      r_b1_wdata  <= 32'h0;
      r_b1_be     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_valid <= w_mem_valid_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_be    <= w_mem_be_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_split     <= w_split_next;
      r_b1_addr   <= w_b1_addr_next;
      r_b1_wdata  <= w_b1_wdata_next;
      r_b1_be     <= w_b1_be_next;
    end
  end

  assign o_mem_valid = r_mem_valid;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed bench for store_data_aligner: a vector table for single requests plus
// hand-written sequences for back-pressure, reset mid-beat and the no-split variant.
module tb_store_data_aligner;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, valid_ns;
  logic [31:0] addr, data;
  logic [1:0]  size;
  logic        mem_ready;

  logic        ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        ns_ready, ns_mem_valid, ns_done, ns_err;
  logic [31:0] ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_data_aligner #(.ALLOW_SPLIT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_addr(addr), .i_data(data), .i_size(size),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .o_done(done), .o_err(err)
  );

  store_data_aligner #(.ALLOW_SPLIT(0)) u_dut_ns (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_ns), .o_ready(ns_ready),
    .i_addr(addr), .i_data(data), .i_size(size),
    .o_mem_valid(ns_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(ns_mem_addr),
    .o_mem_wdata(ns_mem_wdata), .o_mem_be(ns_mem_be), .o_done(ns_done), .o_err(ns_err)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          beats;   // 0 means rejected with o_err
    logic [31:0] b0_addr;
    logic [3:0]  b0_be;
    logic [31:0] b0_wdata;
    logic [31:0] b1_addr;
    logic [3:0]  b1_be;
    logic [31:0] b1_wdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " ready_pre"}, 32'(ready), 32'd1);
    addr = v.addr; data = v.data; size = v.size; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    if (v.beats == 0) begin
      chk({v.name, " err"}, 32'(err), 32'd1);
      chk({v.name, " no_valid"}, 32'(mem_valid), 32'd0);
      @(negedge clk);
      chk({v.name, " err_pulse"}, 32'(err), 32'd0);
    end else begin
      chk({v.name, " b0_valid"}, 32'(mem_valid), 32'd1);
      chk({v.name, " b0_addr"}, mem_addr, v.b0_addr);
      chk({v.name, " b0_be"}, 32'(mem_be), 32'(v.b0_be));
      chk({v.name, " b0_wdata"}, mem_wdata, v.b0_wdata);
      @(negedge clk);
      if (v.beats == 2) begin
        chk({v.name, " b1_valid"}, 32'(mem_valid), 32'd1);
        chk({v.name, " b1_addr"}, mem_addr, v.b1_addr);
        chk({v.name, " b1_be"}, 32'(mem_be), 32'(v.b1_be));
        chk({v.name, " b1_wdata"}, mem_wdata, v.b1_wdata);
        chk({v.name, " b1_no_done"}, 32'(done), 32'd0);
        @(negedge clk);
      end
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " idle_valid"}, 32'(mem_valid), 32'd0);
    end
    chk({v.name, " ready_post"}, 32'(ready), 32'd1);
    $display("vec %s addr=0x%08h size=%0d beats=%0d", v.name, v.addr, v.size, v.beats);
  endtask

  initial begin
    vecs[0] = '{"word_aligned", 32'h100, 32'h1234_5678, SZ_WORD, 1, 32'h100, 4'b1111, 32'h1234_5678, 32'h0, 4'h0, 32'h0};
    vecs[1] = '{"byte_off3", 32'h203, 32'hFFFF_FFAB, SZ_BYTE, 1, 32'h200, 4'b1000, 32'hAB00_0000, 32'h0, 4'h0, 32'h0};
    vecs[2] = '{"half_off2", 32'h302, 32'h1234_BEEF, SZ_HALF, 1, 32'h300, 4'b1100, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0};
    vecs[3] = '{"half_split", 32'h303, 32'h1234_BEEF, SZ_HALF, 2, 32'h300, 4'b1000, 32'hEF00_0000, 32'h304, 4'b0001, 32'h0000_00BE};
    vecs[4] = '{"word_wrap", 32'hFFFF_FFFD, 32'hAABB_CCDD, SZ_WORD, 2, 32'hFFFF_FFFC, 4'b1110, 32'hBBCC_DD00, 32'h0, 4'b0001, 32'h0000_00AA};
    vecs[5] = '{"size_ill", 32'h100, 32'h1234_5678, SZ_ILL, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[6] = '{"byte_off1", 32'h001, 32'h0000_0055, SZ_BYTE, 1, 32'h000, 4'b0010, 32'h0000_5500, 32'h0, 4'h0, 32'h0};
    vecs[7] = '{"half_off1", 32'h001, 32'hFFFF_BEEF, SZ_HALF, 1, 32'h000, 4'b0110, 32'h00BE_EF00, 32'h0, 4'h0, 32'h0};
    vecs[8] = '{"word_off2", 32'h102, 32'h1122_3344, SZ_WORD, 2, 32'h100, 4'b1100, 32'h3344_0000, 32'h104, 4'b0011, 32'h0000_1122};

    rst = 1'b1; valid = 1'b0; valid_ns = 1'b0; addr = '0; data = '0; size = SZ_WORD; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_be", 32'(mem_be), 32'h0);
    chk("rst done_err", {30'h0, done, err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", 32'(ready), 32'd1);
    $display("reset checked");

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-pressure: beat0 must hold steady while memory stalls.
    @(negedge clk);
    mem_ready = 1'b0; addr = 32'h402; data = 32'hCAFE_F00D; size = SZ_HALF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall valid", 32'(mem_valid), 32'd1);
      chk("stall addr", mem_addr, 32'h400);
      chk("stall be", 32'(mem_be), 32'(4'b1100));
      chk("stall wdata", mem_wdata, 32'hF00D_0000);
      chk("stall done_ready", {30'h0, done, ready}, 32'h0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stall done", 32'(done), 32'd1);
    chk("stall idle", 32'(mem_valid), 32'd0);
    $display("seq stall 5 cycles on beat0");

    // Reset while the second beat of a split store is pending.
    @(negedge clk);
    addr = 32'h503; data = 32'h0000_1357; size = SZ_HALF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; mem_ready = 1'b1;
    chk("rstmid b0_be", 32'(mem_be), 32'(4'b1000));
    @(negedge clk);
    chk("rstmid b1_addr", mem_addr, 32'h504);
    chk("rstmid b1_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid valid", 32'(mem_valid), 32'd0);
    chk("rstmid done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid done_after", 32'(done), 32'd0);
    chk("rstmid ready", 32'(ready), 32'd1);
    $display("seq reset during beat1");

    // No-split variant: crossing store rejected, aligned store still issues.
    @(negedge clk);
    addr = 32'h101; data = 32'h1234_5678; size = SZ_WORD; valid_ns = 1'b1;
    @(negedge clk);
    valid_ns = 1'b0;
    chk("ns err", 32'(ns_err), 32'd1);
    chk("ns no_valid", 32'(ns_mem_valid), 32'd0);
    @(negedge clk);
    chk("ns err_pulse", 32'(ns_err), 32'd0);
    chk("ns no_valid2", 32'(ns_mem_valid), 32'd0);
    chk("ns ready", 32'(ns_ready), 32'd1);
    addr = 32'h100; valid_ns = 1'b1;
    @(negedge clk);
    valid_ns = 1'b0;
    chk("ns aligned valid", 32'(ns_mem_valid), 32'd1);
    chk("ns aligned be", 32'(ns_mem_be), 32'(4'b1111));
    chk("ns aligned wdata", ns_mem_wdata, 32'h1234_5678);
    chk("ns aligned addr", ns_mem_addr, 32'h100);
    @(negedge clk);
    chk("ns aligned done", 32'(ns_done), 32'd1);
    $display("seq no-split variant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
